freq_meter: RTL and testbench

//   Gated frequency counter. Counts rising edges of an external, asynchronous

---
 rtl/freq_meter.sv | 170 +++++++++++++++++
 tb/tb_freq_meter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/freq_meter.sv
// freq_meter: gated frequency counter.
// Counts rising edges of an asynchronous input over a window of GATE_CYCLES
// clk cycles. It reports one saturating result per window, and windows run
// back to back.
// Optional feature macro FREQ_METER_PERIOD_EN adds a rise-to-rise period
// measurement (period_cycles / period_valid).
module freq_meter #(
    parameter int unsigned GATE_CYCLES = 50000000,
    parameter int unsigned CNT_W       = 26
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sig_in,
    output logic [CNT_W-1:0] freq_count,
    output logic             freq_valid,
    output logic             freq_ovf
`ifdef FREQ_METER_PERIOD_EN
    ,
    output logic [CNT_W-1:0] period_cycles,
    output logic             period_valid
`endif
);

    localparam int unsigned GATE_W = $clog2(GATE_CYCLES);

    typedef enum logic {IDLE, MEASURE} state_t;

    state_t             state_q, state_d;
    logic [GATE_W-1:0]  gate_q, gate_d;
    logic [CNT_W-1:0]   edge_cnt_q, edge_cnt_d;
    logic               ovf_acc_q, ovf_acc_d;
    logic [CNT_W-1:0]   freq_count_q, freq_count_d;
    logic               freq_valid_q, freq_valid_d;
    logic               freq_ovf_q, freq_ovf_d;
    logic               s1_q, s2_q, s3_q;
    logic               rise;
    logic [CNT_W:0]     edge_sum;
    logic [CNT_W-1:0]   edge_sat;
    logic               edge_of;
    logic               last_cycle;

    // Three-flop input path: two flops resolve metastability, the third gives edge history.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= sig_in;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign rise       = s2_q & ~s3_q;
    assign edge_sum   = {1'b0, edge_cnt_q} + {{CNT_W{1'b0}}, rise};
    assign edge_of    = edge_sum[CNT_W];
    assign edge_sat   = edge_of ? {CNT_W{1'b1}} : edge_sum[CNT_W-1:0];
    assign last_cycle = (gate_q == GATE_W'(GATE_CYCLES - 1));

    // State and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            gate_q       <= '0;
            edge_cnt_q   <= '0;
            ovf_acc_q    <= 1'b0;
            freq_count_q <= '0;
            freq_valid_q <= 1'b0;
            freq_ovf_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            gate_q       <= gate_d;
            edge_cnt_q   <= edge_cnt_d;
            ovf_acc_q    <= ovf_acc_d;
            freq_count_q <= freq_count_d;
            freq_valid_q <= freq_valid_d;
            freq_ovf_q   <= freq_ovf_d;
        end
    end

    // Next-state: window counting, result publication and discard on en drop.
    // NOTE: every signal gets a default first, so no path leaves one unassigned (no latches).
    always_comb begin
        state_d      = state_q;
        gate_d       = '0;
        edge_cnt_d   = '0;
        ovf_acc_d    = 1'b0;
        freq_count_d = freq_count_q;
        freq_valid_d = 1'b0;
        freq_ovf_d   = freq_ovf_q;
        unique case (state_q)
            IDLE: begin
                if (en) state_d = MEASURE;
            end
            MEASURE: begin
                if (!en) begin
                    // Partial window is dropped; the published result stays.
                    state_d = IDLE;
                end else if (last_cycle) begin
                    // The closing cycle's edge belongs to this window; the next one starts at once.
                    freq_count_d = edge_sat;
                    freq_ovf_d   = ovf_acc_q | edge_of;
                    freq_valid_d = 1'b1;
                end else begin
                    gate_d     = gate_q + GATE_W'(1);
                    edge_cnt_d = edge_sat;
                    ovf_acc_d  = ovf_acc_q | edge_of;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign freq_count = freq_count_q;
    assign freq_valid = freq_valid_q;
    assign freq_ovf   = freq_ovf_q;

`ifdef FREQ_METER_PERIOD_EN
    logic [CNT_W-1:0] per_cnt_q, per_cnt_d;
    logic             first_q, first_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             period_valid_q, period_valid_d;
    logic [CNT_W-1:0] per_inc;

    // Saturating per_cnt + 1; it is used both for free-running and for the reported period.
    assign per_inc = (per_cnt_q == {CNT_W{1'b1}}) ? per_cnt_q : per_cnt_q + CNT_W'(1);

    // Period registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            per_cnt_q      <= '0;
            first_q        <= 1'b0;
            period_q       <= '0;
            period_valid_q <= 1'b0;
        end else begin
            per_cnt_q      <= per_cnt_d;
            first_q        <= first_d;
            period_q       <= period_d;
            period_valid_q <= period_valid_d;
        end
    end

    // Rise-to-rise measurement, active only while measuring; the first rise only arms it.
    always_comb begin
        per_cnt_d      = '0;
        first_d        = 1'b0;
        period_d       = period_q;
        period_valid_d = 1'b0;
        if (state_q == MEASURE) begin
            first_d   = first_q;
            per_cnt_d = per_inc;
            if (rise) begin
                per_cnt_d = '0;
                first_d   = 1'b1;
                if (first_q) begin
                    period_d       = per_inc;
                    period_valid_d = 1'b1;
                end
            end
        end
    end

    assign period_cycles = period_q;
    assign period_valid  = period_valid_q;
`endif

endmodule

// File: tb/tb_freq_meter.sv
// Directed bench for freq_meter: two instances share the stimulus.
// Instance A uses GATE_CYCLES=100, CNT_W=8. Instance B uses GATE_CYCLES=100,
// CNT_W=3 to exercise saturation.
module tb_freq_meter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic       sig_in = 1'b0;
    int         sig_period = 0;
    logic       sig_level  = 1'b0;
    int         ph = 0;
    int         tests = 0;
    int         fails = 0;

    logic [7:0] cnt_a;
    logic       valid_a, ovf_a;
    logic [2:0] cnt_b;
    logic       valid_b, ovf_b;
`ifdef FREQ_METER_PERIOD_EN
    logic [7:0] per_a;
    logic       per_valid_a;
    logic [2:0] per_b;
    logic       per_valid_b;
`endif

    freq_meter #(.GATE_CYCLES(100), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .en(en), .sig_in(sig_in),
        .freq_count(cnt_a), .freq_valid(valid_a), .freq_ovf(ovf_a)
`ifdef FREQ_METER_PERIOD_EN
        , .period_cycles(per_a), .period_valid(per_valid_a)
`endif
    );

    freq_meter #(.GATE_CYCLES(100), .CNT_W(3)) dut_b (
        .clk(clk), .rst(rst), .en(en), .sig_in(sig_in),
        .freq_count(cnt_b), .freq_valid(valid_b), .freq_ovf(ovf_b)
`ifdef FREQ_METER_PERIOD_EN
        , .period_cycles(per_b), .period_valid(per_valid_b)
`endif
    );

    always #5 clk = ~clk;

    // Signal generator: a square wave of sig_period clk (high for period/2),
    // or a static level when sig_period is 0. It changes on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (sig_period == 0) begin
                sig_in = sig_level;
            end else begin
                ph     = (ph + 1 >= sig_period) ? 0 : ph + 1;
                sig_in = (ph < sig_period / 2);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Count posedges until instance A publishes a result, with a bounded wait.
    task automatic wait_valid(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!valid_a && n < 300);
        if (!valid_a) check("valid_timeout", {31'd0, valid_a}, 32'd1);
    endtask

    initial begin
        int n;
        int seen;

        // Reset state.
        #23;
        check("rst_count", cnt_a, 0);
        check("rst_valid", valid_a, 0);
        check("rst_ovf", ovf_a, 0);

        // Release with en high and sig_in held low: 1 IDLE cycle + 100.
        en = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        wait_valid(n);
        check("first_latency", n, 101);
        check("low_count", cnt_a, 0);
        check("low_ovf", ovf_a, 0);
        @(posedge clk); #1;
        check("valid_one_cycle", valid_a, 0);

        // Level change to 1: one genuine rise in this window, then none.
        sig_level = 1'b1;
        wait_valid(n);
        check("level_win_len", n, 99);
        check("level_rise_count", cnt_a, 1);
        wait_valid(n);
        check("high_win_len", n, 100);
        check("high_count", cnt_a, 0);

        // Period 10: first window is mixed, the next ones are exact.
        sig_period = 10;
        wait_valid(n);
        wait_valid(n);
        check("p10_win_len", n, 100);
        check("p10_count_a", cnt_a, 10);
        check("p10_ovf_a", ovf_a, 0);
        check("p10_count_b", cnt_b, 7);
        check("p10_ovf_b", ovf_b, 1);
        wait_valid(n);
        check("p10_count_a2", cnt_a, 10);

        // Period 4: 25 edges, saturates the 3-bit instance.
        sig_period = 4;
        wait_valid(n);
        wait_valid(n);
        check("p4_count_a", cnt_a, 25);
        check("p4_ovf_a", ovf_a, 0);
        check("p4_count_b", cnt_b, 7);
        check("p4_ovf_b", ovf_b, 1);

        // Period 20: 5 edges, the overflow flag clears.
        sig_period = 20;
        wait_valid(n);
        wait_valid(n);
        check("p20_count_b", cnt_b, 5);
        check("p20_ovf_b", ovf_b, 0);
        check("p20_count_a", cnt_a, 5);

        // en dropped at gate=50 for 30 clk: nothing is published, the count holds.
        repeat (50) @(posedge clk);
        #1;
        en   = 1'b0;
        seen = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (valid_a) seen++;
        end
        check("partial_no_valid", seen, 0);
        check("partial_hold_count", cnt_a, 5);
        en = 1'b1;
        wait_valid(n);
        check("reenable_latency", n, 101);
        check("reenable_count", cnt_a, 5);

        // Asynchronous reset mid-window.
        sig_period = 0;
        sig_level  = 1'b0;
        repeat (40) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("arst_count_a", cnt_a, 0);
        check("arst_count_b", cnt_b, 0);
        check("arst_valid", valid_a, 0);
        #22 rst = 1'b0;
        wait_valid(n);
        check("arst_latency", n, 101);
        check("arst_result", cnt_a, 0);

`ifdef FREQ_METER_PERIOD_EN
        // Period 7: every pulse reports 7; 140 clk hold exactly 20 rises.
        sig_period = 7;
        repeat (30) @(posedge clk);
        seen = 0;
        repeat (140) begin
            @(posedge clk); #1;
            if (per_valid_a) begin
                seen++;
                check("period7_value", per_a, 7);
            end
        end
        check("period7_pulses", seen, 20);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got 0 expected 1");
        $fatal(1, "simulation time limit");
    end

endmodule
